// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ valid/ready requesters,
// with bounded bursts. Optional per-requester transfer counters under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 4,
   localparam int unsigned GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
`ifdef FIFO_ARB_STATS_EN
   input  logic                          i_stat_clr,
   output logic [NUM_REQ*16-1:0]         o_stat_xfers,
`endif
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic                          o_fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         o_fifo_data,
   input  logic                          i_fifo_full,
   output logic                          o_grant_valid,
   output logic [GW-1:0]                 o_grant_id
);

   localparam int unsigned BW = $clog2(MAX_BURST + 1);

   typedef enum logic {StIdle, StHold} state_e;

   state_e          state_q, state_d;
   logic [GW-1:0]   grant_id_q, grant_id_d;
   logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
   logic [GW-1:0]   rr_winner;
   logic            sel_valid;
   logic            xfer;
   logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign req_data_arr[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
   end

   assign sel_valid = i_req_valid[grant_id_q];
   assign xfer      = (state_q == StHold) && sel_valid && !i_fifo_full;

   // Walk offsets from farthest to nearest so the nearest valid requester after the
   // pointer is written last and wins.
   always_comb begin
      rr_winner = grant_id_q;
      for (int i = int'(NUM_REQ); i > 0; i--) begin
         if (i_req_valid[GW'((int'(grant_id_q) + i) % int'(NUM_REQ))]) begin
            rr_winner = GW'((int'(grant_id_q) + i) % int'(NUM_REQ));
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      burst_cnt_d  = burst_cnt_q;
      o_req_ready  = '0;
      o_fifo_wr_en = 1'b0;
      o_fifo_data  = '0;
      unique case (state_q)
         StIdle: begin
            if (|i_req_valid) begin
               state_d     = StHold;
               grant_id_d  = rr_winner;
               burst_cnt_d = '0;
            end
         end
         StHold: begin
            o_req_ready[grant_id_q] = !i_fifo_full;
            o_fifo_wr_en            = xfer;
            o_fifo_data             = req_data_arr[grant_id_q];
            if (!sel_valid) begin
               state_d = StIdle;
            end else if (xfer) begin
               if (burst_cnt_q == BW'(MAX_BURST - 1)) begin
                  state_d     = StIdle;
                  burst_cnt_d = '0;
               end else begin
                  burst_cnt_d = burst_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         grant_id_q  <= GW'(NUM_REQ - 1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign o_grant_valid = (state_q == StHold);
   assign o_grant_id    = grant_id_q;

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stat_q [NUM_REQ];
   logic [15:0] stat_d [NUM_REQ];

   // Clear wins over increment; counters stick at all-ones.
   always_comb begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         stat_d[k] = stat_q[k];
         if (i_stat_clr) begin
            stat_d[k] = '0;
         end else if (xfer && (grant_id_q == GW'(k)) && (stat_q[k] != 16'hFFFF)) begin
            stat_d[k] = stat_q[k] + 16'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            stat_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            stat_q[k] <= stat_d[k];
         end
      end
   end

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat_out
      assign o_stat_xfers[k*16 +: 16] = stat_q[k];
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized phase, all
// compared cycle by cycle against a behavioural model of grant/burst rules.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int MB = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     valid;
   logic [NR*DW-1:0]  data;
   logic              full;
   logic [NR-1:0]     ready;
   logic              wr_en;
   logic [DW-1:0]     fdata;
   logic              gvalid;
   logic [1:0]        gid;
`ifdef FIFO_ARB_STATS_EN
   logic              stat_clr;
   logic [NR*16-1:0]  stat_xfers;
`endif

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
`ifdef FIFO_ARB_STATS_EN
      .i_stat_clr    (stat_clr),
      .o_stat_xfers  (stat_xfers),
`endif
      .i_req_valid   (valid),
      .i_req_data    (data),
      .o_req_ready   (ready),
      .o_fifo_wr_en  (wr_en),
      .o_fifo_data   (fdata),
      .i_fifo_full   (full),
      .o_grant_valid (gvalid),
      .o_grant_id    (gid)
   );

   always #5 clk = ~clk;

   // Behavioural model: holding flag, grantee, words still allowed in this burst.
   bit  m_hold;
   int  m_gid;
   int  m_left;
   int  m_stat [NR];

   int  checks   = 0;
   int  failures = 0;
   logic [NR-1:0] acc;
   int  wr_total;
   int  gv_cycles;
   bit  prev_gv;
   int  grants [$];
   int  gwords [16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hold = 0;
      m_gid  = NR - 1;
      m_left = 0;
      for (int k = 0; k < NR; k++) m_stat[k] = 0;
   endtask

   // Inputs must be set (at a negedge) before calling; returns at the next negedge.
   task automatic step();
      logic [NR-1:0] er;
      logic          ew;
      logic [DW-1:0] ed;
      bit            clr;
      #1;
      er = '0;
      ew = 1'b0;
      ed = '0;
      if (m_hold) begin
         er[m_gid] = !full;
         ew        = valid[m_gid] && !full;
         ed        = data[m_gid*DW +: DW];
      end
      chk("ready", 64'(ready), 64'(er));
      chk("wr_en", 64'(wr_en), 64'(ew));
      chk("data", 64'(fdata), 64'(ed));
      chk("grant_valid", 64'(gvalid), 64'(m_hold));
      chk("grant_id", 64'(gid), 64'(m_gid));
`ifdef FIFO_ARB_STATS_EN
      for (int k = 0; k < NR; k++) chk("stat", 64'(stat_xfers[k*16 +: 16]), 64'(m_stat[k]));
      clr = stat_clr;
`else
      clr = 0;
`endif
      acc = er & valid;
      if (wr_en) wr_total++;
      if (gvalid) gv_cycles++;
      if (gvalid && !prev_gv) grants.push_back(int'(gid));
      if (wr_en && grants.size() > 0 && grants.size() <= 16) gwords[grants.size()-1]++;
      prev_gv = gvalid;
      @(posedge clk);
      if (clr) begin
         for (int k = 0; k < NR; k++) m_stat[k] = 0;
      end else if (ew && m_stat[m_gid] < 65535) begin
         m_stat[m_gid]++;
      end
      if (!m_hold) begin
         if (valid != 0) begin
            for (int i = 1; i <= NR; i++) begin
               if (valid[(m_gid + i) % NR]) begin
                  m_gid = (m_gid + i) % NR;
                  break;
               end
            end
            m_hold = 1;
            m_left = MB;
         end
      end else if (!valid[m_gid]) begin
         m_hold = 0;
      end else if (!full) begin
         m_left--;
         if (m_left == 0) m_hold = 0;
      end
      @(negedge clk);
   endtask

   // Asserted at a negedge; outputs checked before any clock edge, released at the next negedge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_ready", 64'(ready), 64'(0));
      chk("rst_wr_en", 64'(wr_en), 64'(0));
      chk("rst_data", 64'(fdata), 64'(0));
      chk("rst_grant_valid", 64'(gvalid), 64'(0));
      chk("rst_grant_id", 64'(gid), 64'(NR - 1));
      model_reset();
      prev_gv   = 0;
      wr_total  = 0;
      gv_cycles = 0;
      grants.delete();
      for (int k = 0; k < 16; k++) gwords[k] = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NR-1:0] pend;
      int            n;
      rst_n = 1'b0;
      valid = '0;
      data  = '0;
      full  = 1'b0;
`ifdef FIFO_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      @(negedge clk);
      do_reset();

      // Single requester, three-cycle valid window.
      valid = 4'b0010;
      data[1*DW +: DW] = 32'hA5;
      step();
      chk("t1_grant_id", 64'(gid), 64'd1);
      step();
      step();
      chk("t1_words", 64'(wr_total), 64'd2);
      valid = '0;
      step();
      chk("t1_released", 64'(gvalid), 64'd0);

      // All requesters continuously valid.
      do_reset();
      for (int k = 0; k < NR; k++) data[k*DW +: DW] = $urandom;
      valid = '1;
      for (int c = 0; c < 25; c++) step();
      chk("t2_ngrants", 64'(grants.size()), 64'd5);
      for (int i = 0; i < 5 && i < grants.size(); i++) begin
         chk("t2_order", 64'(grants[i]), 64'(i % NR));
         chk("t2_words", 64'(gwords[i]), 64'(MB));
      end
      chk("t2_hold_cycles", 64'(gv_cycles), 64'd20);

      // Stall mid-burst.
      do_reset();
      valid = 4'b0100;
      data[2*DW +: DW] = $urandom;
      step();
      step();
      step();
      full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("t3_stall_ready", 64'(ready), 64'd0);
         chk("t3_stall_wr", 64'(wr_en), 64'd0);
         chk("t3_stall_hold", 64'(gvalid), 64'd1);
      end
      full = 1'b0;
      step();
      step();
      chk("t3_words", 64'(wr_total), 64'(MB));
      chk("t3_exhausted", 64'(gvalid), 64'd0);

      // Early release hands over to the other waiting requester.
      do_reset();
      valid = 4'b1001;
      data[0 +: DW]    = $urandom;
      data[3*DW +: DW] = $urandom;
      step();
      chk("t4_first", 64'(gid), 64'd0);
      step();
      step();
      valid = 4'b1000;
      step();
      chk("t4_idle", 64'(gvalid), 64'd0);
      step();
      chk("t4_next", 64'(gid), 64'd3);
      chk("t4_hold", 64'(gvalid), 64'd1);

      // Reset in the middle of a burst.
      do_reset();
      valid = '1;
      step();
      step();
      do_reset();
      step();
      chk("t5_after_rst", 64'(gid), 64'd0);

      // Randomized traffic with requesters honouring the hold-until-accepted rule.
      do_reset();
      pend = '0;
      for (int c = 0; c < 500; c++) begin
         for (int k = 0; k < NR; k++) begin
            if (!pend[k] && $urandom_range(0, 1) == 1) begin
               pend[k] = 1'b1;
               data[k*DW +: DW] = $urandom;
            end
         end
         valid = pend;
         full  = ($urandom_range(0, 3) == 0);
         step();
         pend = pend & ~acc;
      end
      full  = 1'b0;
      valid = '0;
      step();

`ifdef FIFO_ARB_STATS_EN
      // Saturation and clear of the transfer counters.
      do_reset();
      valid = 4'b0010;
      n = 0;
      while (m_stat[1] < 65535 && n < 90000) begin
         data[1*DW +: DW] = $urandom;
         step();
         n++;
      end
      for (int c = 0; c < 10; c++) step();
      chk("t6_saturated", 64'(stat_xfers[1*16 +: 16]), 64'hFFFF);
      valid    = '0;
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      step();
      chk("t6_cleared", 64'(stat_xfers[1*16 +: 16]), 64'd0);
`else
      n = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
